// File: rtl/mux4_arbiter.sv
// Four-input round-robin arbiter with registered one-hot grant and mux output.
// Define MUX4_ARB_TIMEOUT_EN to limit each grant to HOLD_MAX consecutive cycles.
module mux4_arbiter #(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       gnt,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux4_arbiter: HOLD_MAX must be in 1..255");
  end

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic       win_found;
  logic [1:0] win_idx;
  logic       timeout;
  logic       rel;

  assign s1   = sel[1];
  assign s0   = sel[0];
  assign busy = (state == GRANT);

  // Search starts after the last owner, so the current owner is tried last.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    win_found = 1'b0;
    win_idx   = ptr;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = ptr + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
  logic [7:0] hold_cnt;

  assign timeout = (hold_cnt == HOLD_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
    end else if (state == IDLE || rel) begin
      hold_cnt <= win_found ? 8'd1 : 8'd0;
    end else if (hold_cnt != HOLD_LIM) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // While granting, ptr is the owner index.
  assign rel = (state == GRANT) && (!req[ptr] || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd3;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
    end else if (state == IDLE || rel) begin
      if (win_found) begin
        state <= GRANT;
        ptr   <= win_idx;
        sel   <= win_idx;
        gnt   <= 4'b0001 << win_idx;
      end else begin
        state <= IDLE;
        gnt   <= 4'b0000;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= busy;
      if (busy) begin
        case (sel)
          2'd0:    y <= i0;
          2'd1:    y <= i1;
          2'd2:    y <= i2;
          default: y <= i3;
        endcase
      end else begin
        y <= '0;
      end
    end
  end

endmodule

// File: doc/mux4_arbiter.md
MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter WIDTH, default 1: bit width of each data input and of y.
REQ-002 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles per owner (range 1..255); used only under MUX4_ARB_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  4  request vector; req[n] belongs to requester n, level-sensitive.
REQ-006 i0, i1, i2, i3  input  WIDTH each  requester data inputs.
REQ-007 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-008 s1, s0  output  1 each  registered mux select; {s1,s0} equals index of current or last owner.
REQ-009 busy  output  1  high while in GRANT state.
REQ-010 y  output  WIDTH  registered mux output.
REQ-011 y_valid  output  1  high when y carries owner data.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (gnt=0000, busy=0) and GRANT (gnt one-hot, busy=1).
REQ-013 A round-robin pointer SHALL hold the last granted index; search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-014 IDLE: on an edge with req!=0, next state GRANT; winner is first set req bit in search order; gnt, {s1,s0}, ptr update on that edge (grant latency 1 cycle).
REQ-015 IDLE with req=0000: remain IDLE; {s1,s0} and ptr hold.
REQ-016 GRANT: gnt and {s1,s0} SHALL hold while req[owner]=1 and no release condition occurs.
REQ-017 Release condition: req[owner]=0 on a clock edge, or (macro enabled) hold count reached HOLD_MAX.
REQ-018 On release edge with other bits of req set: switch directly to the next winner in search order (no idle cycle), ptr updated, hold count restarts at 1.
REQ-019 On timeout release where only req[owner] is set: re-grant same owner, hold count restarts at 1.
REQ-020 On release edge with req=0000 (after owner drop): go to IDLE, gnt=0000.
REQ-021 Hold count SHALL be 1 in the first grant cycle, increment each GRANT cycle, saturate at HOLD_MAX, and never wrap.
REQ-022 y SHALL register the selected input (i0..i3 per gnt) each edge while busy=1, else register 0; y_valid SHALL register busy; y/y_valid lag gnt by exactly 1 cycle.
REQ-023 Requests arriving simultaneously SHALL be resolved solely by search order; a lower index has no fixed priority.
REQ-024 gnt SHALL never have more than one bit set, including across switch edges.

Reset
REQ-025 rst_n low SHALL immediately, independent of clk, force IDLE, gnt=0000, {s1,s0}=00, busy=0, y=0, y_valid=0, hold count=0, ptr=3 (so requester 0 wins first).
REQ-026 Reset asserted mid-grant SHALL abort the grant with no further y_valid pulse; first grant after release follows REQ-025 pointer value.
REQ-027 On rst_n deassertion, req SHALL be sampled from the first following rising edge.

Configuration
REQ-028 Macro MUX4_ARB_TIMEOUT_EN defined: HOLD_MAX timeout release per REQ-017/REQ-019 is active.
REQ-029 Macro MUX4_ARB_TIMEOUT_EN undefined: no timeout; owner holds until req[owner] drops; hold counter and HOLD_MAX logic are not built, HOLD_MAX ignored.

Verification
REQ-030 Reset, then req=0101 held -> edge 1: gnt=0001, {s1,s0}=00, busy=1; edge 2: y=i0, y_valid=1.
REQ-031 Owner 0 drops req with req=0100 -> next edge gnt=0100, {s1,s0}=10, no IDLE cycle; req=0000 afterwards -> gnt=0000, y_valid=0 one cycle later.
REQ-032 Fairness: req=1111 held, drop each owner after 2 cycles -> grant order 0,1,2,3,0 with ptr wrap 3->0.
REQ-033 Macro on, HOLD_MAX=4, req=0011 held -> gnt=0001 for exactly 4 cycles, then 0010 for 4, then 0001; req=0001 alone -> gnt stays 0001 continuously. Macro off -> gnt=0001 indefinitely.
REQ-034 rst_n pulsed low mid-grant between edges -> gnt, y_valid, busy go 0 without a clock edge; after release with req=1000 -> gnt=1000 on first edge.
